// File: rtl/fpu_arbiter.sv
// Two-port arbiter sharing one pipelined FP adder; sequences run/stall, returns results per port.
// Define FPU_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module fpu_arbiter #(
    parameter int LAT_MAX = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r0_req,
    input  logic [1:0]  r0_op,
    input  logic [31:0] r0_x,
    input  logic [31:0] r0_y,
    output logic        r0_ack,
    output logic        r0_done,
    output logic [31:0] r0_z,
    input  logic        r1_req,
    input  logic [1:0]  r1_op,
    input  logic [31:0] r1_x,
    input  logic [31:0] r1_y,
    output logic        r1_ack,
    output logic        r1_done,
    output logic [31:0] r1_z,
    output logic        fa_run,
    output logic        fa_u,
    output logic        fa_v,
    output logic        fa_en,
    output logic [31:0] fa_x,
    output logic [31:0] fa_y,
    input  logic        fa_stall,
    input  logic [31:0] fa_z,
    output logic        busy,
    output logic        err
);

    localparam int CW = (LAT_MAX > 2) ? $clog2(LAT_MAX) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LAT_MAX - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          gnt, gnt_n;
    logic [31:0]   x_n, y_n, z0_n, z1_n, res;
    logic          u_n, v_n, err_n;
    logic          ack0_n, ack1_n, done0_n, done1_n;
    logic          any_req, win;
    logic [1:0]    sel_op;
    logic [31:0]   sel_x, sel_y;

    assign any_req = r0_req | r1_req;

`ifdef FPU_ARB_RR_EN
    logic ptr, ptr_n;
    // ptr remembers the last granted requester; a tie goes to the other one
    assign win = (r0_req && r1_req) ? ~ptr : r1_req;
`else
    assign win = ~r0_req;
`endif

    assign sel_op = win ? r1_op : r0_op;
    assign sel_x  = win ? r1_x  : r0_x;
    assign sel_y  = win ? r1_y  : r0_y;
    assign res    = fa_stall ? 32'h0 : fa_z;
    assign busy   = (state != IDLE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        gnt_n   = gnt;
        x_n     = fa_x;
        y_n     = fa_y;
        u_n     = fa_u;
        v_n     = fa_v;
        z0_n    = r0_z;
        z1_n    = r1_z;
        err_n   = err;
        ack0_n  = 1'b0;
        ack1_n  = 1'b0;
        done0_n = 1'b0;
        done1_n = 1'b0;
`ifdef FPU_ARB_RR_EN
        ptr_n   = ptr;
`endif
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_n = RUN;
                    cnt_n   = '0;
                    gnt_n   = win;
                    x_n     = sel_x;
                    // subtract is an add with the sign of y flipped
                    y_n     = (sel_op == 2'b11) ? {~sel_y[31], sel_y[30:0]} : sel_y;
                    u_n     = (sel_op == 2'b01);
                    v_n     = (sel_op == 2'b10);
                    ack0_n  = ~win;
                    ack1_n  = win;
`ifdef FPU_ARB_RR_EN
                    ptr_n   = win;
`endif
                end
            end
            RUN: begin
                cnt_n = cnt + CW'(1);
                if (!fa_stall || cnt == CNT_LAST) begin
                    state_n = DONE;
                    if (fa_stall) begin
                        err_n = 1'b1;
                    end
                    if (gnt) begin
                        z1_n    = res;
                        done1_n = 1'b1;
                    end else begin
                        z0_n    = res;
                        done0_n = 1'b1;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // All handshake and adder outputs are registered from the next-state decision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            gnt     <= 1'b0;
            fa_x    <= 32'h0;
            fa_y    <= 32'h0;
            fa_u    <= 1'b0;
            fa_v    <= 1'b0;
            fa_run  <= 1'b0;
            fa_en   <= 1'b0;
            r0_z    <= 32'h0;
            r1_z    <= 32'h0;
            r0_ack  <= 1'b0;
            r1_ack  <= 1'b0;
            r0_done <= 1'b0;
            r1_done <= 1'b0;
            err     <= 1'b0;
`ifdef FPU_ARB_RR_EN
            ptr     <= 1'b1;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            gnt     <= gnt_n;
            fa_x    <= x_n;
            fa_y    <= y_n;
            fa_u    <= u_n;
            fa_v    <= v_n;
            fa_run  <= (state_n == RUN);
            fa_en   <= (state_n != IDLE);
            r0_z    <= z0_n;
            r1_z    <= z1_n;
            r0_ack  <= ack0_n;
            r1_ack  <= ack1_n;
            r0_done <= done0_n;
            r1_done <= done1_n;
            err     <= err_n;
`ifdef FPU_ARB_RR_EN
            ptr     <= ptr_n;
`endif
        end
    end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter: behavioural adder stub plus directed and randomized scenarios.
module tb_fpu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0_req = 1'b0, r1_req = 1'b0;
    logic [1:0]  r0_op = 2'b00, r1_op = 2'b00;
    logic [31:0] r0_x = 32'h0, r0_y = 32'h0, r1_x = 32'h0, r1_y = 32'h0;
    logic        r0_ack, r0_done, r1_ack, r1_done;
    logic [31:0] r0_z, r1_z;
    logic        fa_run, fa_u, fa_v, fa_en, fa_stall;
    logic [31:0] fa_x, fa_y, fa_z;
    logic        busy, err;

    fpu_arbiter #(.LAT_MAX(7)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_op(r0_op), .r0_x(r0_x), .r0_y(r0_y),
        .r0_ack(r0_ack), .r0_done(r0_done), .r0_z(r0_z),
        .r1_req(r1_req), .r1_op(r1_op), .r1_x(r1_x), .r1_y(r1_y),
        .r1_ack(r1_ack), .r1_done(r1_done), .r1_z(r1_z),
        .fa_run(fa_run), .fa_u(fa_u), .fa_v(fa_v), .fa_en(fa_en),
        .fa_x(fa_x), .fa_y(fa_y), .fa_stall(fa_stall), .fa_z(fa_z),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    wire [137:0] all_outs = {r0_ack, r0_done, r0_z, r1_ack, r1_done, r1_z,
                             fa_run, fa_u, fa_v, fa_en, fa_x, fa_y, busy, err};

    // Single-precision <-> real conversion, valid for normal exactly-representable values
    function automatic real f2r(input logic [31:0] b);
        int e;
        logic [10:0] e11;
        if (b[30:0] == 31'h0) return 0.0;
        e = int'(b[30:23]) - 127 + 1023;
        e11 = e[10:0];
        return $bitstoreal({b[31], e11, b[22:0], 29'h0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Adder stub: holds stall for cur_lat RUN cycles, then presents the result
    int run_cycles = 0;
    int cur_lat = 3;
    int stub_lat = 3;
    bit rand_lat = 1'b0;

    function automatic logic [31:0] stub_result(input logic [31:0] x, input logic [31:0] y,
                                                input logic u, input logic v);
        real f;
        if (u) return r2f(real'($signed(x)));
        if (v) begin
            f = $floor(f2r(x));
            if (f > 2.0e9 || f < -2.0e9) return 32'h0;
            return 32'($rtoi(f));
        end
        return r2f(f2r(x) + f2r(y));
    endfunction

    always @(posedge clk) begin
        if (fa_run) run_cycles <= run_cycles + 1;
        else begin
            run_cycles <= 0;
            cur_lat <= rand_lat ? int'($urandom_range(0, 4)) : stub_lat;
        end
    end
    assign fa_stall = fa_run && (run_cycles < cur_lat);
    assign fa_z = stub_result(fa_x, fa_y, fa_u, fa_v);

    typedef struct { int port; int cyc; logic [31:0] z; } evt_t;
    evt_t ack_q[$];
    evt_t done_q[$];
    int phase_q[$];
    int en_only_len = 0;
    int done_total = 0;

    always @(negedge clk) begin
        if (r0_ack) ack_q.push_back('{0, cyc, 32'h0});
        if (r1_ack) ack_q.push_back('{1, cyc, 32'h0});
        if (r0_done) done_q.push_back('{0, cyc, r0_z});
        if (r1_done) done_q.push_back('{1, cyc, r1_z});
        if (r0_done || r1_done) done_total <= done_total + 1;
        if (fa_en && !fa_run) en_only_len <= en_only_len + 1;
        else if (en_only_len != 0) begin
            phase_q.push_back(en_only_len);
            en_only_len <= 0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic req, input logic [1:0] op,
                           input logic [31:0] x, input logic [31:0] y);
        if (p == 0) begin r0_req = req; r0_op = op; r0_x = x; r0_y = y; end
        else        begin r1_req = req; r1_op = op; r1_x = x; r1_y = y; end
    endtask

    task automatic wait_ack(input int p, input int budget, output int at, output bit ok);
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if ((p == 0) ? r0_ack : r1_ack) begin ok = 1'b1; at = cyc; end
        end
    endtask

    task automatic wait_done(input int p, input int budget, output int at,
                             output logic [31:0] z, output bit ok);
        ok = 1'b0;
        at = -1;
        z = 32'h0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if ((p == 0) ? r0_done : r1_done) begin
                ok = 1'b1; at = cyc; z = (p == 0) ? r0_z : r1_z;
            end
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        set_req(0, 1'b0, 2'b00, 32'h0, 32'h0);
        set_req(1, 1'b0, 2'b00, 32'h0, 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if (all_outs !== 138'h0) begin errors++; $display("[TB] FAIL reset_hold outs got %h want 0", all_outs); end
        rst_n = 1'b1;
        tick();
        checks++;
        if (all_outs !== 138'h0) begin errors++; $display("[TB] FAIL reset_release outs got %h want 0", all_outs); end
    endtask

    task automatic test_single_add();
        int n, a, d, r1_events;
        bit ok;
        logic [31:0] z;
        tick();
        ack_q.delete();
        done_q.delete();
        n = cyc;
        set_req(0, 1'b1, 2'b00, 32'h3F800000, 32'h40000000);
        wait_ack(0, 20, a, ok);
        set_req(0, 1'b0, 2'b00, 32'h0, 32'h0);
        checks++;
        if (!ok || a != n + 1) begin errors++; $display("[TB] FAIL add_ack cycle got %0d want %0d", a, n + 1); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL add_busy got %b want 1", busy); end
        wait_done(0, 20, d, z, ok);
        checks++;
        if (!ok || d != n + 5) begin errors++; $display("[TB] FAIL add_done cycle got %0d want %0d", d, n + 5); end
        checks++;
        if (z !== 32'h40400000) begin errors++; $display("[TB] FAIL add_z got %h want 40400000", z); end
        r1_events = 0;
        foreach (ack_q[i]) if (ack_q[i].port == 1) r1_events++;
        foreach (done_q[i]) if (done_q[i].port == 1) r1_events++;
        checks++;
        if (r1_events != 0 || r1_z !== 32'h0) begin
            errors++; $display("[TB] FAIL add_r1_quiet events %0d z %h want 0 and 0", r1_events, r1_z);
        end
    endtask

    task automatic test_subtract();
        int a, d;
        bit ok;
        logic [31:0] z;
        tick();
        set_req(1, 1'b1, 2'b11, 32'h40400000, 32'h3F800000);
        wait_ack(1, 20, a, ok);
        set_req(1, 1'b0, 2'b00, 32'h0, 32'h0);
        checks++;
        if (!ok || fa_y !== 32'hBF800000 || fa_x !== 32'h40400000) begin
            errors++; $display("[TB] FAIL sub_operands x %h y %h want 40400000 bf800000", fa_x, fa_y);
        end
        tick();
        checks++;
        if (fa_run !== 1'b1 || fa_y !== 32'hBF800000 || fa_u !== 1'b0 || fa_v !== 1'b0) begin
            errors++; $display("[TB] FAIL sub_run_hold run %b y %h u %b v %b", fa_run, fa_y, fa_u, fa_v);
        end
        wait_done(1, 20, d, z, ok);
        checks++;
        if (!ok || z !== 32'h40000000) begin errors++; $display("[TB] FAIL sub_z got %h want 40000000", z); end
        checks++;
        if (r0_z !== 32'h40400000) begin errors++; $display("[TB] FAIL sub_r0_hold got %h want 40400000", r0_z); end
    endtask

    task automatic test_stuck_stall();
        int n, a, d, runs;
        bit ok, got;
        logic [31:0] z;
        tick();
        stub_lat = 1000;
        n = cyc;
        set_req(0, 1'b1, 2'b00, 32'h3F800000, 32'h40000000);
        wait_ack(0, 20, a, ok);
        set_req(0, 1'b0, 2'b00, 32'h0, 32'h0);
        checks++;
        if (!ok || a != n + 1) begin errors++; $display("[TB] FAIL stuck_ack cycle got %0d want %0d", a, n + 1); end
        runs = 0;
        got = 1'b0;
        d = -1;
        for (int i = 0; i < 30 && !got; i++) begin
            if (fa_run) runs++;
            if (r0_done) begin got = 1'b1; d = cyc; end
            else tick();
        end
        checks++;
        if (!got || d != n + 8) begin errors++; $display("[TB] FAIL stuck_done cycle got %0d want %0d", d, n + 8); end
        checks++;
        if (runs != 7) begin errors++; $display("[TB] FAIL stuck_run_cycles got %0d want 7", runs); end
        checks++;
        if (r0_z !== 32'h0 || err !== 1'b1) begin errors++; $display("[TB] FAIL stuck_z_err z %h err %b want 0 1", r0_z, err); end
        stub_lat = 3;
        // Re-request in the DONE cycle: not sampled until IDLE, so ack comes one cycle later
        n = cyc;
        set_req(0, 1'b1, 2'b01, 32'd5, 32'h0);
        wait_ack(0, 20, a, ok);
        set_req(0, 1'b0, 2'b00, 32'h0, 32'h0);
        checks++;
        if (!ok || a != n + 2 || fa_u !== 1'b1 || fa_v !== 1'b0) begin
            errors++; $display("[TB] FAIL flt_ack cycle %0d want %0d u %b v %b", a, n + 2, fa_u, fa_v);
        end
        wait_done(0, 20, d, z, ok);
        checks++;
        if (!ok || z !== 32'h40A00000 || d != n + 6) begin
            errors++; $display("[TB] FAIL flt_done z %h cycle %0d want 40a00000 %0d", z, d, n + 6);
        end
        checks++;
        if (err !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky got %b want 1", err); end
    endtask

    task automatic test_reset_mid_op();
        int n, a, d, dn, rel;
        bit ok;
        logic [31:0] z;
        tick();
        n = cyc;
        set_req(1, 1'b1, 2'b00, 32'h41200000, 32'h41A00000);
        tick();
        tick();
        checks++;
        if (busy !== 1'b1 || cyc != n + 2) begin errors++; $display("[TB] FAIL midop_setup busy %b cycle %0d", busy, cyc); end
        dn = done_q.size();
        rst_n = 1'b0;
        #1;
        checks++;
        if (all_outs !== 138'h0) begin errors++; $display("[TB] FAIL midop_async outs got %h want 0", all_outs); end
        tick();
        tick();
        checks++;
        if (all_outs !== 138'h0) begin errors++; $display("[TB] FAIL midop_held outs got %h want 0", all_outs); end
        rel = cyc;
        rst_n = 1'b1;
        wait_ack(1, 20, a, ok);
        set_req(1, 1'b0, 2'b00, 32'h0, 32'h0);
        checks++;
        if (!ok || a != rel + 1) begin errors++; $display("[TB] FAIL midop_reack cycle got %0d want %0d", a, rel + 1); end
        checks++;
        if (done_q.size() != dn) begin errors++; $display("[TB] FAIL midop_no_done got %0d want %0d", done_q.size(), dn); end
        wait_done(1, 20, d, z, ok);
        checks++;
        if (!ok || z !== 32'h41F00000) begin errors++; $display("[TB] FAIL midop_z got %h want 41f00000", z); end
    endtask

    task automatic test_simultaneous();
        int n, rr, exp_p;
        logic [31:0] exp_z;
`ifdef FPU_ARB_RR_EN
        rr = 1;
`else
        rr = 0;
`endif
        apply_reset();
        done_q.delete();
        n = cyc;
        set_req(0, 1'b1, 2'b00, 32'h3F800000, 32'h40000000);
        set_req(1, 1'b1, 2'b00, 32'h40800000, 32'h40800000);
        for (int i = 0; i < 80 && done_q.size() < 4; i++) tick();
        set_req(0, 1'b0, 2'b00, 32'h0, 32'h0);
        set_req(1, 1'b0, 2'b00, 32'h0, 32'h0);
        checks++;
        if (done_q.size() < 4) begin
            errors++; $display("[TB] FAIL simul_count got %0d want 4", done_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                exp_p = rr ? (i % 2) : 0;
                exp_z = (exp_p == 1) ? 32'h41000000 : 32'h40400000;
                checks++;
                if (done_q[i].port != exp_p || done_q[i].z !== exp_z) begin
                    errors++;
                    $display("[TB] FAIL simul_grant%0d port %0d z %h want %0d %h", i, done_q[i].port, done_q[i].z, exp_p, exp_z);
                end
                checks++;
                if ((i == 0 && done_q[i].cyc != n + 5) || (i > 0 && done_q[i].cyc - done_q[i-1].cyc != 6)) begin
                    errors++; $display("[TB] FAIL simul_timing%0d cycle %0d start %0d", i, done_q[i].cyc, n);
                end
            end
        end
        for (int i = 0; i < 20 && busy; i++) tick();
    endtask

    task automatic random_port(input int p, input int n_ops);
        int gap, a, b, at, dt;
        bit ok;
        logic [1:0] op;
        logic [31:0] x, y, exp_z, z;
        for (int k = 0; k < n_ops; k++) begin
            gap = int'($urandom_range(0, 3));
            repeat (gap) tick();
            op = 2'($urandom_range(0, 3));
            a = int'($urandom_range(0, 2000)) - 1000;
            b = int'($urandom_range(0, 2000)) - 1000;
            y = $urandom;
            case (op)
                2'b00: begin x = r2f(real'(a)); y = r2f(real'(b)); exp_z = r2f(real'(a + b)); end
                2'b11: begin x = r2f(real'(a)); y = r2f(real'(b)); exp_z = r2f(real'(a - b)); end
                2'b01: begin x = 32'(a); exp_z = r2f(real'(a)); end
                default: begin
                    x = r2f(real'(a) / 4.0);
                    exp_z = 32'((a >= 0) ? a / 4 : -((-a + 3) / 4));
                end
            endcase
            set_req(p, 1'b1, op, x, y);
            wait_ack(p, 60, at, ok);
            set_req(p, 1'b0, 2'b00, 32'h0, 32'h0);
            checks++;
            if (!ok) begin errors++; $display("[TB] FAIL rand_ack port %0d op %0d no ack", p, op); end
            wait_done(p, 60, dt, z, ok);
            checks++;
            if (!ok || z !== exp_z) begin
                errors++; $display("[TB] FAIL rand_z port %0d op %0d x %h y %h got %h want %h", p, op, x, y, z, exp_z);
            end
        end
    endtask

    task automatic test_random();
        tick();
        rand_lat = 1'b1;
        fork
            random_port(0, 10);
            random_port(1, 10);
        join
        rand_lat = 1'b0;
        checks++;
        if (err !== 1'b0) begin errors++; $display("[TB] FAIL rand_err got %b want 0", err); end
    endtask

    task automatic test_protocol();
        repeat (3) tick();
        checks++;
        if (phase_q.size() != done_total) begin
            errors++; $display("[TB] FAIL proto_phases got %0d want %0d", phase_q.size(), done_total);
        end
        foreach (phase_q[i]) begin
            checks++;
            if (phase_q[i] != 1) begin errors++; $display("[TB] FAIL proto_len%0d got %0d want 1", i, phase_q[i]); end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        test_reset();
        test_single_add();
        test_subtract();
        test_stuck_stall();
        test_reset_mid_op();
        test_simultaneous();
        test_random();
        test_protocol();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/fpu_arbiter.md
# fpu_arbiter

Shares one pipelined floating-point adder between two requesters, for example the CPU core and an FP coprocessor/DMA engine. Each request is latched, the adder's `run`/`stall` protocol is sequenced, the result is captured and returned to the owning requester. The block sits between the requesters and the adder. It is the only driver of the adder's `run`, `u`, `v`, `en`, `x` and `y` inputs.

## Interface

Parameters:
- `LAT_MAX`, default 7: maximum RUN cycles with `fa_stall` high before the operation is aborted.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk` in 1: clock.
  - `rst_n` in 1: reset.
- Requester 0 (identical set for requester 1, prefix `r1_`):
  - `r0_req` in 1: request; held high with operands stable until `r0_ack`.
  - `r0_op` in 2: operation. 00 add, 01 FLT (int→float), 10 FLOOR (float→int), 11 subtract.
  - `r0_x` in 32: operand x.
  - `r0_y` in 32: operand y.
  - `r0_ack` out 1: one-cycle pulse; request accepted.
  - `r0_done` out 1: one-cycle pulse; `r0_z` updated.
  - `r0_z` out 32: result register for this port; holds until the next `r0_done`.
- Adder side:
  - `fa_run` out 1: adder run.
  - `fa_u` out 1: adder FLT select.
  - `fa_v` out 1: adder FLOOR select.
  - `fa_en` out 1: adder pipeline enable.
  - `fa_x` out 32: adder operand x.
  - `fa_y` out 32: adder operand y.
  - `fa_stall` in 1: adder busy.
  - `fa_z` in 32: adder result.
- Status:
  - `busy` out 1: state ≠ IDLE.
  - `err` out 1: sticky timeout flag.

## Operation

- **Reset:** all outputs are 0. This covers `ack`, `done`, `z` registers, `fa_*`, `busy` and `err`. State is IDLE. The round-robin pointer points to requester 1, so requester 0 wins the first tie.
- **Operand latch:** registered on grant. `fa_x`/`fa_y` drive from it and stay constant through RUN.
- **Op decode (registered):**
  - 00: u=0, v=0.
  - 01: u=1, v=0.
  - 10: u=0, v=1.
  - 11: u=0, v=0, and `fa_y[31]` = ~y[31].
- **FSM states:**
  - **IDLE:** `fa_run`=0, `fa_en`=0.
    - If any request is pending: select the winner, latch operands/op/grant, pulse `ack` of the winner, clear the cycle counter, go to RUN.
  - **RUN:** `fa_run`=1, `fa_en`=1, counter increments each cycle.
    - If `fa_stall`=0: capture `fa_z` into the granted port's `z`, go to DONE.
    - Else if counter = `LAT_MAX`-1: write 0 to the granted `z`, set `err`, go to DONE.
  - **DONE:** `fa_run`=0, `fa_en`=1, which returns the adder's internal state to 0. Pulse the granted port's `done`, go to IDLE.
- The ungranted requester keeps `req` high. It is served on a later IDLE cycle; no request is dropped.
- **Request in DONE:** a `req` asserted during DONE is not sampled until IDLE.
- **Same requester again:** may re-request in the cycle of its own `done`.
- `err` clears only on reset. Operation continues normally after a timeout.
- **Reset mid-operation:** returns to IDLE immediately. No `done` is issued for the interrupted op. `z` registers clear.

## Timing

- `req` is sampled high in IDLE at cycle N. Then:
  - N+1: `ack` high, state RUN.
  - N+1..N+4: RUN, with `fa_stall` high for 3 cycles.
  - Edge ending N+4: `z` captured.
  - N+5: DONE, `done` high and `z` valid.
  - N+6: IDLE.
- Request-to-result latency: 5 cycles. Back-to-back throughput: one op per 6 cycles.
- `ack`, `done` and all `fa_*` outputs are registered. There is no combinational path from `req` or `fa_stall` to any output.
- A timeout aborts after `LAT_MAX` RUN cycles. `done` follows in the next cycle.

## Configuration

- `FPU_ARB_RR_EN` defined: round-robin. On simultaneous requests, grant the requester not granted last; the pointer updates on every grant.
- `FPU_ARB_RR_EN` undefined: fixed priority. Requester 0 always wins ties; requester 1 is served only when `r0_req` is low in IDLE. The pointer logic is removed.

## Test plan

- **Single add:** `r0_req`, op 00, x=0x3F800000, y=0x40000000 at cycle N.
  - Expect `r0_ack` at N+1, `r0_done` at N+5, `r0_z`=0x40400000.
  - Expect `r1_*` outputs unchanged.
- **Subtract on port 1:** op 11, x=0x40400000, y=0x3F800000.
  - Expect `fa_y`=0xBF800000 during RUN and `r1_z`=0x40000000.
- **Simultaneous requests held high after reset:**
  - With the macro: grant order r0, r1, r0, r1, with `done` pulses 6 cycles apart.
  - Without the macro: r0 is granted continuously while `r0_req` is high.
- **Stuck stall:** adder stub holds `fa_stall`=1.
  - Expect RUN for 7 cycles, `done` with `z`=0x00000000, `err`=1.
  - A following request completes normally and `err` stays 1.
- **Reset mid-op:** drop `rst_n` at N+2.
  - Expect all outputs 0 asynchronously and no `done`.
  - After release, the held request is acked one cycle after first IDLE sampling.
- **Adder protocol check:** each op shows exactly one cycle with `fa_run`=0 and `fa_en`=1 between RUN phases.
